// File: rtl/load_store_unit.sv
// load_store_unit -- initiator side of the core's data-memory interface.
// Turns RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-granular
// memory_read/memory_write cycles. The memory has no byte enables, so SB/SH
// run a read-modify-write sequence (READ then WRITE).
// Optional feature macro: LSU_MISALIGN_CHECK_EN -- when defined, misaligned
// halfword/word accesses complete immediately with req_error=1.
module load_store_unit #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  done,
   output logic [31:0]           load_data,
   output logic                  req_error,
   output logic                  memory_read,
   output logic                  memory_write,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [31:0]           write_data,
   input  logic [31:0]           read_data
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t                  state, state_next;
   logic                    store_q;
   logic [2:0]              funct3_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [31:0]             wdata_q;
   logic [31:0]             word_q;
   logic [1:0]              offset_q;

   logic                    illegal;
   logic                    misaligned;
   logic                    req_bad;
   logic [7:0]              rd_byte;
   logic [15:0]             rd_half;
   logic [31:0]             load_value;
   logic [31:0]             merged;

   assign offset_q = addr_q[1:0];

   // Classify the incoming request: illegal funct3 for its direction.
   always_comb begin
      if (req_store)
         illegal = (req_funct3 > 3'b010);
      else
         illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
   end

`ifdef LSU_MISALIGN_CHECK_EN
   // Halfwords must be 2-byte aligned, words 4-byte aligned.
   always_comb begin
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   end
`else
   // Low address bits are simply ignored by access size.
   always_comb begin
      misaligned = 1'b0;
   end
`endif

   assign req_bad = illegal || misaligned;

   // Extract and extend the addressed lane from the word being read.
   always_comb begin
      rd_byte = read_data[{offset_q, 3'b000} +: 8];
      rd_half = read_data[{offset_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  load_value = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_value = {{16{rd_half[15]}}, rd_half};
         3'b100:  load_value = {24'b0, rd_byte};
         3'b101:  load_value = {16'b0, rd_half};
         default: load_value = read_data;
      endcase
   end

   // Merge sub-word store data into the word captured during READ.
   always_comb begin
      merged = word_q;
      case (funct3_q[1:0])
         2'b00:   merged[{offset_q, 3'b000} +: 8]      = wdata_q[7:0];
         2'b01:   merged[{offset_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state and Moore-decoded outputs.
   // NOTE: every output gets a default first so no path through the case can infer a latch.
   always_comb begin
      state_next   = state;
      req_ready    = 1'b0;
      done         = 1'b0;
      memory_read  = 1'b0;
      memory_write = 1'b0;
      address      = '0;
      write_data   = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_bad)
                  state_next = DONE;
               else if (req_store && (req_funct3 == 3'b010))
                  state_next = WRITE;
               else
                  state_next = READ;
            end
         end
         READ: begin
            memory_read = 1'b1;
            address     = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            state_next  = store_q ? WRITE : DONE;
         end
         WRITE: begin
            memory_write = 1'b1;
            address      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            write_data   = merged;
            state_next   = DONE;
         end
         default: begin
            done       = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   // Request latch, read-word capture and held results.
   always_ff @(posedge clk) begin
      if (reset) begin
         store_q   <= 1'b0;
         funct3_q  <= 3'b000;
         addr_q    <= '0;
         wdata_q   <= '0;
         word_q    <= '0;
         load_data <= '0;
         req_error <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  store_q   <= req_store;
                  funct3_q  <= req_funct3;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  req_error <= req_bad;
               end
            end
            READ: begin
               word_q <= read_data;
               if (!store_q)
                  load_data <= load_value;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a transaction-level model computes
// latency, strobe counts, write data and load results from the RV32I rules;
// one negedge compare process checks the DUT against it every cycle.
`timescale 1ns/1ps
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready, done, req_error, memory_read, memory_write;
   logic [31:0] load_data, address, write_data, read_data;

   int n_checks = 0;
   int n_fail   = 0;

   // transaction model state
   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   bit          tx_pending = 0;
   int          cyc, rd_cnt, wr_cnt;
   int          exp_lat, exp_reads, exp_writes;
   logic        exp_err, exp_is_load;
   logic [31:0] exp_load, exp_wdata, exp_addr;
   logic [31:0] got_load, got_wdata;
   logic        got_err;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .done(done), .load_data(load_data), .req_error(req_error),
      .memory_read(memory_read), .memory_write(memory_write),
      .address(address), .write_data(write_data), .read_data(read_data)
   );

   // Word-addressed memory: combinational read, full-word write at posedge.
   assign read_data = memory_read ? mem[address[7:2]] : 32'hDEAD0BAD;
   always @(posedge clk) if (memory_write) mem[address[7:2]] <= write_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model's expectations.
   always @(negedge clk) begin
      if (!reset) begin
         check("rd_wr_exclusive", {31'b0, memory_read & memory_write}, 32'h0);
         if (tx_pending) begin
            cyc++;
            check("busy_not_ready", {31'b0, req_ready}, 32'h0);
            if (memory_read) begin
               rd_cnt++;
               check("read_addr", address, exp_addr);
            end
            if (memory_write) begin
               wr_cnt++;
               check("write_addr", address, exp_addr);
               check("write_data", write_data, exp_wdata);
               got_wdata = write_data;
            end
            if (done) begin
               check("latency", cyc, exp_lat);
               check("req_error", {31'b0, req_error}, {31'b0, exp_err});
               check("read_count", rd_cnt, exp_reads);
               check("write_count", wr_cnt, exp_writes);
               if (exp_is_load && !exp_err) check("load_data", load_data, exp_load);
               got_load   = load_data;
               got_err    = req_error;
               tx_pending = 0;
            end
         end else begin
            check("idle_ready", {31'b0, req_ready}, 32'h1);
            check("idle_done", {31'b0, done}, 32'h0);
            check("idle_strobes", {30'b0, memory_read, memory_write}, 32'h0);
         end
      end
   end

   // Issue one request and wait for the compare process to see it complete.
   task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
      int          size, off, idx;
      logic [31:0] w, val, mask;
      bit          bad;
      idx  = (a / 4) % 64;
      w    = ref_mem[idx];
      size = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
      bad  = st ? !(f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd3, 3'd6, 3'd7});
`ifdef LSU_MISALIGN_CHECK_EN
      if (a % size != 0) bad = 1;
`endif
      off = (a % 4) - ((a % 4) % size);
      exp_err = bad; exp_is_load = !st; exp_addr = a & ~32'h3;
      exp_load = 'x; exp_wdata = 'x;
      if (bad) begin
         exp_lat = 1; exp_reads = 0; exp_writes = 0;
      end else if (!st) begin
         exp_lat = 2; exp_reads = 1; exp_writes = 0;
         val = w >> (8 * off);
         if (size < 4) begin
            mask = ~(32'hFFFFFFFF << (8 * size));
            val  = val & mask;
            if (f3 < 4 && val >= (32'h1 << (8 * size - 1))) val = val | ~mask;
         end
         exp_load = val;
      end else if (size == 4) begin
         exp_lat = 2; exp_reads = 0; exp_writes = 1; exp_wdata = wd;
         ref_mem[idx] = wd;
      end else begin
         exp_lat = 3; exp_reads = 1; exp_writes = 1;
         mask = (~(32'hFFFFFFFF << (8 * size))) << (8 * off);
         exp_wdata = (w & ~mask) | ((wd << (8 * off)) & mask);
         ref_mem[idx] = exp_wdata;
      end
      @(negedge clk);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_store = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      cyc = 0; rd_cnt = 0; wr_cnt = 0; tx_pending = 1;
      for (int i = 0; i < 8 && tx_pending; i++) @(posedge clk);
      n_checks++;
      if (tx_pending) begin
         n_fail++;
         $display("FAIL done_timeout: no done within 8 cycles of accept (addr 0x%08h)", a);
         tx_pending = 0;
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'b0, req_ready}, 32'h1);
      check("rst_done", {31'b0, done}, 32'h0);
      check("rst_error", {31'b0, req_error}, 32'h0);
      check("rst_load_data", load_data, 32'h0);
      check("rst_strobes", {30'b0, memory_read, memory_write}, 32'h0);
      check("rst_address", address, 32'h0);
      check("rst_write_data", write_data, 32'h0);
      reset = 1'b0;

      // Fill the whole memory with SW so model and memory agree.
      for (int i = 0; i < 64; i++) do_req(1'b1, 3'b010, i * 4, $urandom);

      // Directed cases with literal expectations.
      do_req(1'b1, 3'b010, 32'h10, 32'h8899AABB);
      do_req(1'b0, 3'b010, 32'h10, 32'h0);
      check("lw_literal", got_load, 32'h8899AABB);
      do_req(1'b0, 3'b000, 32'h11, 32'h0);
      check("lb_literal", got_load, 32'hFFFFFFAA);
      do_req(1'b0, 3'b100, 32'h11, 32'h0);
      check("lbu_literal", got_load, 32'h000000AA);
      do_req(1'b0, 3'b001, 32'h12, 32'h0);
      check("lh_literal", got_load, 32'hFFFF8899);
      do_req(1'b0, 3'b101, 32'h12, 32'h0);
      check("lhu_literal", got_load, 32'h00008899);
      do_req(1'b1, 3'b010, 32'h20, 32'h11223344);
      do_req(1'b1, 3'b000, 32'h22, 32'hDEADBEEF);
      check("sb_merge_literal", got_wdata, 32'h11EF3344);
      do_req(1'b0, 3'b010, 32'h20, 32'h0);
      check("lw_after_sb_literal", got_load, 32'h11EF3344);
      do_req(1'b1, 3'b010, 32'h30, 32'hCAFEF00D);
      check("sw_literal", got_wdata, 32'hCAFEF00D);
      do_req(1'b0, 3'b001, 32'h13, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
      check("lh_misaligned_err", {31'b0, got_err}, 32'h1);
`else
      check("lh_13_literal", got_load, 32'hFFFF8899);
`endif

      // Randomized traffic.
      for (int i = 0; i < 300; i++)
         do_req(1'($urandom), 3'($urandom), $urandom_range(0, 255), $urandom);

      // Reset during the READ cycle of an SB drops the store.
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h41; req_wdata = 32'h00000055;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("mid_rst_read_cycle", {31'b0, memory_read}, 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("mid_rst_ready", {31'b0, req_ready}, 32'h1);
      check("mid_rst_strobes", {30'b0, memory_read, memory_write}, 32'h0);
      check("mid_rst_done", {31'b0, done}, 32'h0);
      repeat (3) @(posedge clk);
      do_req(1'b0, 3'b010, 32'h40, 32'h0);
      do_req(1'b1, 3'b011, 32'h44, 32'h12345678);
      check("store_f3_011_err", {31'b0, got_err}, 32'h1);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
